// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR datapath and its output buffer.
package fir_pkg;

  localparam int FIR_DATA_W     = 16;
  localparam int FIR_FIFO_DEPTH = 8;

  typedef logic [FIR_DATA_W-1:0] fir_sample_t;

  // Saturating increment used by event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fir_fifo_ctrl.sv
// Pointer, occupancy and handshake control for the FIR output FIFO.
// Pointers carry one extra MSB and wrap modulo 2*DEPTH.
module fir_fifo_ctrl
  import fir_pkg::*;
#(
  parameter int DEPTH = FIR_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vin,
  input  logic          ready,
  output logic          push,
  output logic          pop,
  output logic          drop,
  output logic          vout,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr_next,
  output logic [AW:0]   level,
  output logic [AW:0]   level_next
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_LEVEL = (AW+1)'(0);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr_next;
  logic [AW:0] rd_ptr_next;
  logic        full;

  // Handshake decode and next-state arithmetic.
  always_comb begin
    full         = (level == FULL_LEVEL);
    vout         = (level != ZERO_LEVEL);
    pop          = vout & ready;
    push         = vin & (~full | pop);
    drop         = vin & full & ~pop;
    wr_ptr_next  = wr_ptr + (AW+1)'(push);
    rd_ptr_next  = rd_ptr + (AW+1)'(pop);
    level_next   = level + (AW+1)'(push) - (AW+1)'(pop);
    wr_addr      = wr_ptr[AW-1:0];
    rd_addr_next = rd_ptr_next[AW-1:0];
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= ZERO_LEVEL;
      rd_ptr <= ZERO_LEVEL;
      level  <= ZERO_LEVEL;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      level  <= level_next;
    end
  end

endmodule

// File: rtl/fir_out_fifo.sv
// First-word-fall-through output buffer behind myfir with sticky overflow flag.
// Optional drop counter enabled by defining FIR_OUT_FIFO_DROP_CNT_EN.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_FIFO_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_W-1:0]        DIN,
  input  logic                     VIN,
  output logic [DATA_W-1:0]        DOUT,
  output logic                     VOUT,
  input  logic                     READY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVF,
  input  logic                     CLR_OVF
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]              DROP_CNT
`endif
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [AW:0] LV0 = (AW+1)'(0);
  localparam logic [AW:0] LV1 = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head_next;
  logic              push;
  logic              pop;
  logic              drop;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr_next;
  logic [AW:0]       level_next;

  fir_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk          (CLK),
    .rst          (RST),
    .vin          (VIN),
    .ready        (READY),
    .push         (push),
    .pop          (pop),
    .drop         (drop),
    .vout         (VOUT),
    .wr_addr      (wr_addr),
    .rd_addr_next (rd_addr_next),
    .level        (LEVEL),
    .level_next   (level_next)
  );

  // Next head: the incoming sample when no older entry survives this cycle, else storage.
  always_comb begin
    head_next = DOUT;
    if (level_next == LV0) begin
      head_next = DOUT;
    end else if ((LEVEL == LV0) || ((LEVEL == LV1) && pop)) begin
      head_next = DIN;
    end else begin
      head_next = mem[rd_addr_next];
    end
  end

  // Storage array write port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
    end else if (push) begin
      mem[wr_addr] <= DIN;
    end
  end

  // Registered head output, held while empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DOUT <= {DATA_W{1'b0}};
    end else begin
      DOUT <= head_next;
    end
  end

  // Sticky overflow; a drop outranks a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OVF <= 1'b0;
    end else if (drop) begin
      OVF <= 1'b1;
    end else if (CLR_OVF) begin
      OVF <= 1'b0;
    end
  end

`ifdef FIR_OUT_FIFO_DROP_CNT_EN
  // Saturating count of discarded samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DROP_CNT <= 16'h0000;
    end else if (drop) begin
      DROP_CNT <= CLR_OVF ? 16'h0001 : sat_inc16(DROP_CNT);
    end else if (CLR_OVF) begin
      DROP_CNT <= 16'h0000;
    end
  end
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed and randomised-ready bench for fir_out_fifo with a queue-based reference model.
module tb_fir_out_fifo;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        vin;
  logic [15:0] dout;
  logic        vout;
  logic        ready;
  logic [3:0]  level;
  logic        ovf;
  logic        clr;
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  fir_out_fifo #(.DATA_W(16), .DEPTH(8)) dut (
    .CLK     (clk),
    .RST     (rst),
    .DIN     (din),
    .VIN     (vin),
    .DOUT    (dout),
    .VOUT    (vout),
    .READY   (ready),
    .LEVEL   (level),
    .OVF     (ovf),
    .CLR_OVF (clr)
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
    ,
    .DROP_CNT(drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a queue, applied at each rising edge.
  logic [15:0] q[$];
  logic [15:0] m_last;
  logic [15:0] m_cnt;
  bit          m_ovf;
  bit          started = 1'b0;

  initial begin
    bit m_pop, m_push, m_full, m_drop;
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_ovf   = 1'b0;
        m_cnt   = 16'h0000;
        m_last  = 16'h0000;
        started = 1'b1;
      end else begin
        m_pop  = (q.size() > 0) && ready;
        m_full = (q.size() == 8);
        m_push = vin && (!m_full || m_pop);
        m_drop = vin && m_full && !m_pop;
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(din);
        if (m_drop) begin
          m_ovf = 1'b1;
          m_cnt = clr ? 16'h0001 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'h0001);
        end else if (clr) begin
          m_ovf = 1'b0;
          m_cnt = 16'h0000;
        end
        if (q.size() > 0) m_last = q[0];
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("vout", {31'd0, vout}, {31'd0, q.size() != 0});
        chk("dout", {16'd0, dout}, {16'd0, (q.size() != 0) ? q[0] : m_last});
        chk("level", {28'd0, level}, q.size());
        chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
        chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_cnt});
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; din = 16'h0000; ready = 1'b0; clr = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_vout", {31'd0, vout}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    // Single push with consumer ready.
    vin = 1'b1; din = 16'h1234; ready = 1'b1;
    step();
    vin = 1'b0;
    chk("single_vout", {31'd0, vout}, 32'd1);
    chk("single_dout", {16'd0, dout}, 32'h1234);
    step();
    chk("single_empty", {31'd0, vout}, 32'd0);
    chk("single_level", {28'd0, level}, 32'd0);
    chk("single_hold", {16'd0, dout}, 32'h1234);

    // Fill to full with consumer stalled.
    ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      vin = 1'b1; din = 16'(i);
      step();
    end
    vin = 1'b0;
    chk("fill_level", {28'd0, level}, 32'd8);
    chk("fill_ovf", {31'd0, ovf}, 32'd0);

    // Drop while full.
    vin = 1'b1; din = 16'hAAAA;
    step();
    vin = 1'b0;
    chk("drop_ovf", {31'd0, ovf}, 32'd1);
    chk("drop_level", {28'd0, level}, 32'd8);
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
    chk("drop_cnt1", {16'd0, drop_cnt}, 32'd1);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", {31'd0, ovf}, 32'd0);

    // Push and pop together while full.
    vin = 1'b1; din = 16'h0009; ready = 1'b1;
    step();
    vin = 1'b0; ready = 1'b0;
    chk("pp_level", {28'd0, level}, 32'd8);
    chk("pp_head", {16'd0, dout}, 32'd2);
    chk("pp_ovf", {31'd0, ovf}, 32'd0);

    // Drain: 2..9, the dropped AAAA must not appear.
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", {16'd0, dout}, 32'(2 + i));
      step();
    end
    chk("drain_empty", {31'd0, vout}, 32'd0);
    ready = 1'b0;

    // Drop coinciding with clear: set wins.
    for (int i = 0; i < 8; i++) begin
      vin = 1'b1; din = 16'(16'h0010 + i);
      step();
    end
    din = 16'hAAAA; clr = 1'b1;
    step();
    vin = 1'b0; clr = 1'b0;
    chk("setwins_ovf", {31'd0, ovf}, 32'd1);
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
    chk("setwins_cnt", {16'd0, drop_cnt}, 32'd1);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clear_alone_ovf", {31'd0, ovf}, 32'd0);
`ifdef FIR_OUT_FIFO_DROP_CNT_EN
    chk("clear_alone_cnt", {16'd0, drop_cnt}, 32'd0);
`endif

    // Continuous input, random stalls, reset mid-stream.
    for (int i = 0; i < 40; i++) begin
      vin = 1'b1; din = 16'($urandom_range(0, 65535));
      ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      vin = 1'b1; din = 16'($urandom_range(0, 65535));
      ready = ($urandom_range(0, 9) < 7);
      step();
    end
    vin = 1'b0; ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("final_level", {28'd0, level}, 32'd0);
    chk("final_vout", {31'd0, vout}, 32'd0);
    chk("final_ovf", {31'd0, ovf}, 32'd0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fir_out_fifo.md
# fir_out_fifo

Output buffer sitting directly downstream of `myfir`: captures every valid filtered sample (`DOUT`/`VOUT` of the filter, which has no backpressure) and re-presents it to the consumer (`data_sink` or next stage) over a valid/ready handshake. It decouples the filter's free-running output from a consumer that may stall, and flags any sample lost to a full buffer. Storage is a register-array FIFO with first-word-fall-through output.

## Interface
- `DATA_W`, 16: sample width, matching the filter output.
- `DEPTH`, 8: number of entries; must be a power of two, at least 2.
- `CLK`  in  1: single clock, all logic on rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `DIN`  in  DATA_W: filtered sample from `myfir.DOUT`.
- `VIN`  in  1: sample-valid from `myfir.VOUT`; there is no ready back to the filter.
- `DOUT`  out  DATA_W: head-of-FIFO sample.
- `VOUT`  out  1: head valid (FIFO non-empty).
- `READY`  in  1: consumer accepts `DOUT` this cycle.
- `LEVEL`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `OVF`  out  1: sticky overflow flag.
- `CLR_OVF`  in  1: one-cycle pulse clearing `OVF` (and the drop counter when compiled in).

## Operation
- Push = `VIN && (!full || pop)`; pop = `VOUT && READY`.
- Push and pop in the same cycle are both honoured, including when full; `LEVEL` is unchanged.
- `VIN` while full with no pop: sample discarded, storage untouched, `OVF` set to 1 next cycle.
- `OVF` holds until `RST` or `CLR_OVF`. If a drop and `CLR_OVF` occur in the same cycle, set wins (`OVF` = 1).
- `READY` while empty: no effect; pointers and `LEVEL` hold.
- Pointers are `$clog2(DEPTH)+1` bits. The extra MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH with no special case.
- `DOUT` = mem[rd_ptr] whenever `VOUT` = 1. When `VOUT` = 0, `DOUT` holds its last head value (0 after reset).
- Data is passed unmodified: no rounding or saturation.

## Timing
- Reset values: `VOUT` = 0, `DOUT` = 0, `LEVEL` = 0, `OVF` = 0, both pointers 0. Array contents are don't-care but are cleared to 0.
- `RST` mid-operation flushes all entries next cycle. A `VIN` in the reset cycle is ignored.
- Latency: a push at edge N into an empty FIFO gives `VOUT` = 1 with that `DOUT` after edge N (one cycle). Pop is combinationally acknowledged by `READY`; the next head appears after the same edge.
- `LEVEL` and `OVF` are registered and update one edge after the causing event.
- Sustained throughput: one sample per cycle in and out.

## Configuration
- `FIR_OUT_FIFO_DROP_CNT_EN` defined:
  - Adds output `DROP_CNT` (16 bits): counts discarded samples.
  - Increments once per drop and saturates at 16'hFFFF.
  - Reset to 0 by `RST` and by `CLR_OVF`. A drop in the same cycle as `CLR_OVF` gives 1.
- Undefined: the `DROP_CNT` port and its counter are absent; all other behaviour is identical.

## Structure
- Shared package `fir_pkg` holds:
  - `FIR_DATA_W` = 16.
  - The `fir_sample_t` typedef (logic [15:0]).
  - The default depth constant, shared with `myfir`-side benches.
- One sub-module, `fir_fifo_ctrl`: pointer/full/empty/`LEVEL` logic parameterised by `DEPTH`. The top level holds the storage array, `OVF`, and the optional counter.

## Test plan
- Reset then single push `DIN` = 16'h1234, `READY` = 1 → `VOUT` = 1 with `DOUT` = 16'h1234 one cycle later, then `VOUT` = 0, `LEVEL` back to 0.
- `READY` = 0, push 8 samples 1..8 → `LEVEL` = 8, `OVF` = 0. Then `READY` = 1 → `DOUT` sequence 1..8 over 8 consecutive cycles.
- Full with `READY` = 0, push 16'hAAAA → sample dropped, `OVF` = 1, `LEVEL` = 8. With macro: `DROP_CNT` = 1. Drained order still 1..8.
- Full, same-cycle push 16'h0009 with `READY` = 1 → head 1 popped, 9 accepted, `LEVEL` stays 8, `OVF` stays 0.
- Drop and `CLR_OVF` in same cycle → `OVF` = 1 (and `DROP_CNT` = 1). A later `CLR_OVF` alone → `OVF` = 0, `DROP_CNT` = 0.
- Continuous `VIN` with random `READY`, more than 3·DEPTH samples (pointer wrap), `RST` asserted mid-stream → scoreboard matches all accepted samples. After reset: `LEVEL` = 0, `VOUT` = 0, `OVF` = 0.
